memory_access_stage: RTL and testbench

DLX memory (MEM) stage for the udlx pipeline: consumes the EX/MEM register outputs, performs the data-memory load/store over a req/ack bus to a multi-cycle data memory, stalls upstream while the access is in flight, and drives the MEM/WB register. It ends the EX/MEM interface on the consumer side and produces the final write-back value: loaded data or the ALU result.

---
 rtl/dlx_mem_pkg.sv | 18 +
 rtl/memory_access_stage_if.sv | 32 +++
 rtl/mem_access_timer.sv | 39 +++
 rtl/memory_access_stage.sv | 148 ++++++++++++++
 tb/tb_memory_access_stage.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dlx_mem_pkg.sv
// Shared types and constants for the udlx MEM stage: FSM states, bubble values and
// the width helper for the access timeout counter.
package dlx_mem_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StAccess
  } mem_state_e;

  // Fields forced low when MEM/WB takes a bubble; all other fields still load.
  localparam logic BubbleRegWrEn     = 1'b0;
  localparam logic BubbleSelectNewPc = 1'b0;

  function automatic int unsigned timeout_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the data memory (slave).
interface memory_access_stage_if #(
  parameter int unsigned MEM_ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH     = 32
) ();

  logic                      dmem_req;
  logic                      dmem_we;
  logic [MEM_ADDR_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0]     dmem_wdata;
  logic                      dmem_ack;
  logic [DATA_WIDTH-1:0]     dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_access_timer.sv
// Counts no-ack ACCESS cycles; expire_o flags the MEM_TIMEOUT-th one. Saturates, never wraps.
module mem_access_timer
  import dlx_mem_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int unsigned CntWidth = timeout_width(MEM_TIMEOUT);
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(MEM_TIMEOUT - 1);
  localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(MEM_TIMEOUT);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = inc_i && (cnt_q == LastCnt);

endmodule

// File: rtl/memory_access_stage.sv
// udlx MEM stage: issues the data-memory access over the req/ack bus, stalls upstream
// while it is in flight, and drives the MEM/WB register.
module memory_access_stage
  import dlx_mem_pkg::*;
#(
  parameter int unsigned PC_WIDTH       = 20,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MEM_ADDR_WIDTH = 20,
  parameter int unsigned MEM_TIMEOUT    = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mem_data_rd_en_in,
  input  logic                      mem_data_wr_en_in,
  input  logic [DATA_WIDTH-1:0]     mem_data_in,
  input  logic [DATA_WIDTH-1:0]     alu_data_in,
  input  logic                      reg_wr_en_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
  input  logic                      write_back_mux_sel_in,
  input  logic                      select_new_pc_in,
  input  logic [PC_WIDTH-1:0]       new_pc_in,
  memory_access_stage_if.master     dmem,
  output logic                      stall_out,
  output logic                      bus_error_out,
  output logic                      reg_wr_en_out,
  output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_out,
  output logic [DATA_WIDTH-1:0]     wb_data_out,
  output logic                      select_new_pc_out,
  output logic [PC_WIDTH-1:0]       new_pc_out
);

  mem_state_e                state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      we_q, we_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic                      reg_wr_en_q, reg_wr_en_d;
  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_q, reg_wr_addr_d;
  logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
  logic                      sel_pc_q, sel_pc_d;
  logic [PC_WIDTH-1:0]       new_pc_q, new_pc_d;
  logic                      bus_error_q, bus_error_d;
  logic                      access, aligned, stall, timer_clr, timer_inc, expire;

  assign access  = mem_data_rd_en_in | mem_data_wr_en_in;
  assign aligned = (alu_data_in[1:0] == 2'b00);

  mem_access_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (timer_clr),
    .inc_i   (timer_inc),
    .expire_o(expire)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    stall         = 1'b0;
    timer_clr     = 1'b0;
    timer_inc     = 1'b0;
    bus_error_d   = 1'b0;
    // Default is a bubble that still carries the current inputs.
    reg_wr_en_d   = BubbleRegWrEn;
    sel_pc_d      = BubbleSelectNewPc;
    reg_wr_addr_d = reg_wr_addr_in;
    wb_data_d     = alu_data_in;
    new_pc_d      = new_pc_in;
    unique case (state_q)
      StIdle: begin
        if (!access) begin
          reg_wr_en_d = reg_wr_en_in;
          sel_pc_d    = select_new_pc_in;
        end else if (aligned) begin
          stall     = 1'b1;
          addr_d    = alu_data_in[MEM_ADDR_WIDTH+1:2];
          we_d      = mem_data_wr_en_in;
          wdata_d   = mem_data_in;
          timer_clr = 1'b1;
          state_d   = StAccess;
        end else begin
          bus_error_d = 1'b1;
        end
      end
      StAccess: begin
        if (dmem.dmem_ack) begin
          reg_wr_en_d = reg_wr_en_in;
          sel_pc_d    = select_new_pc_in;
          wb_data_d   = write_back_mux_sel_in ? dmem.dmem_rdata : alu_data_in;
          state_d     = StIdle;
        end else begin
          timer_inc = 1'b1;
          if (expire) begin
            bus_error_d = 1'b1;
            state_d     = StIdle;
          end else begin
            stall = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_wr_addr_q <= '0;
      wb_data_q     <= '0;
      sel_pc_q      <= 1'b0;
      new_pc_q      <= '0;
      bus_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_wr_addr_q <= reg_wr_addr_d;
      wb_data_q     <= wb_data_d;
      sel_pc_q      <= sel_pc_d;
      new_pc_q      <= new_pc_d;
      bus_error_q   <= bus_error_d;
    end
  end

  // Upstream must not be held while the stage itself is in reset.
  assign stall_out         = stall & rst_n;
  assign dmem.dmem_req     = (state_q == StAccess);
  assign dmem.dmem_we      = we_q;
  assign dmem.dmem_addr    = addr_q;
  assign dmem.dmem_wdata   = wdata_q;
  assign bus_error_out     = bus_error_q;
  assign reg_wr_en_out     = reg_wr_en_q;
  assign reg_wr_addr_out   = reg_wr_addr_q;
  assign wb_data_out       = wb_data_q;
  assign select_new_pc_out = sel_pc_q;
  assign new_pc_out        = new_pc_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: a per-instruction timeline model predicts every
// cycle's outputs, backed by literal checks on the headline scenarios.
module tb_memory_access_stage;

  localparam int unsigned PW = 20;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned AW = 20;
  localparam int unsigned TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_en, wr_en, reg_wr_en_in, wb_sel, sel_pc_in;
  logic [DW-1:0] mem_data, alu;
  logic [RW-1:0] reg_wr_addr_in;
  logic [PW-1:0] new_pc_in;
  logic          stall_out, bus_error_out, reg_wr_en_out, select_new_pc_out;
  logic [RW-1:0] reg_wr_addr_out;
  logic [DW-1:0] wb_data_out;
  logic [PW-1:0] new_pc_out;

  memory_access_stage_if #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  memory_access_stage #(
    .PC_WIDTH(PW), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .MEM_ADDR_WIDTH(AW), .MEM_TIMEOUT(TO)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .mem_data_rd_en_in    (rd_en),
    .mem_data_wr_en_in    (wr_en),
    .mem_data_in          (mem_data),
    .alu_data_in          (alu),
    .reg_wr_en_in         (reg_wr_en_in),
    .reg_wr_addr_in       (reg_wr_addr_in),
    .write_back_mux_sel_in(wb_sel),
    .select_new_pc_in     (sel_pc_in),
    .new_pc_in            (new_pc_in),
    .dmem                 (bus),
    .stall_out            (stall_out),
    .bus_error_out        (bus_error_out),
    .reg_wr_en_out        (reg_wr_en_out),
    .reg_wr_addr_out      (reg_wr_addr_out),
    .wb_data_out          (wb_data_out),
    .select_new_pc_out    (select_new_pc_out),
    .new_pc_out           (new_pc_out)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cnt_stall = 0, cnt_req = 0, cnt_berr = 0;

  // Expected outputs: x_* for this cycle's bus/stall, e_* for the registered MEM/WB view,
  // n_* for what MEM/WB must hold after the coming edge.
  logic          x_req, x_stall, x_we;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wdata;
  logic          e_wr_en, e_sel_pc, e_fields, e_berr;
  logic [RW-1:0] e_wr_addr;
  logic [DW-1:0] e_wb;
  logic [PW-1:0] e_new_pc;
  logic          n_wr_en, n_sel_pc, n_fields, n_berr;
  logic [RW-1:0] n_wr_addr;
  logic [DW-1:0] n_wb;
  logic [PW-1:0] n_new_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  task automatic compare_cycle();
    chk("dmem_req", bus.dmem_req, x_req);
    chk("stall_out", stall_out, x_stall);
    if (x_req) begin
      chk("dmem_we", bus.dmem_we, x_we);
      chk("dmem_addr", bus.dmem_addr, x_addr);
      chk("dmem_wdata", bus.dmem_wdata, x_wdata);
    end
    chk("bus_error_out", bus_error_out, e_berr);
    chk("reg_wr_en_out", reg_wr_en_out, e_wr_en);
    chk("select_new_pc_out", select_new_pc_out, e_sel_pc);
    if (e_fields) begin
      chk("reg_wr_addr_out", reg_wr_addr_out, e_wr_addr);
      chk("wb_data_out", wb_data_out, e_wb);
      chk("new_pc_out", new_pc_out, e_new_pc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_cycle();
    cnt_stall += int'(stall_out);
    cnt_req   += int'(bus.dmem_req);
    cnt_berr  += int'(bus_error_out);
    @(posedge clk);
    #1;
    e_wr_en = n_wr_en; e_sel_pc = n_sel_pc; e_fields = n_fields; e_berr = n_berr;
    e_wr_addr = n_wr_addr; e_wb = n_wb; e_new_pc = n_new_pc;
  endtask

  task automatic bubble(input logic berr);
    n_wr_en = 1'b0; n_sel_pc = 1'b0; n_fields = 1'b0; n_berr = berr;
  endtask

  task automatic model_reset();
    x_req = 0; x_stall = 0;
    e_wr_en = 0; e_sel_pc = 0; e_fields = 1; e_berr = 0; e_wr_addr = '0; e_wb = '0;
    e_new_pc = '0;
  endtask

  task automatic set_inputs(input logic rd, input logic wr, input logic [DW-1:0] md,
                            input logic [DW-1:0] a, input logic rwe, input logic [RW-1:0] rwa,
                            input logic wbs, input logic spc, input logic [PW-1:0] npc);
    rd_en = rd; wr_en = wr; mem_data = md; alu = a; reg_wr_en_in = rwe;
    reg_wr_addr_in = rwa; wb_sel = wbs; sel_pc_in = spc; new_pc_in = npc;
  endtask

  // One instruction from arrival to completion; ack_at = ACCESS cycle that sees ack (0 = never).
  task automatic do_instr(input logic rd, input logic wr, input logic [DW-1:0] md,
                          input logic [DW-1:0] a, input logic rwe, input logic [RW-1:0] rwa,
                          input logic wbs, input logic spc, input logic [PW-1:0] npc,
                          input int ack_at, input logic [DW-1:0] rdata);
    bit done = 0;
    set_inputs(rd, wr, md, a, rwe, rwa, wbs, spc, npc);
    bus.dmem_ack = 1'b0;
    x_req = 1'b0;
    if (!(rd || wr)) begin
      x_stall = 0;
      n_wr_en = rwe; n_sel_pc = spc; n_fields = 1; n_berr = 0;
      n_wr_addr = rwa; n_wb = a; n_new_pc = npc;
      step();
    end else if (a[1:0] != 2'b00) begin
      x_stall = 0; bubble(1'b1);
      step();
    end else begin
      x_stall = 1; bubble(1'b0);
      step();
      x_req = 1; x_we = wr; x_addr = a[AW+1:2]; x_wdata = md;
      for (int c = 1; c <= int'(TO) && !done; c++) begin
        if (c == ack_at) begin
          bus.dmem_ack = 1'b1; bus.dmem_rdata = rdata; x_stall = 0;
          n_wr_en = rwe; n_sel_pc = spc; n_fields = 1; n_berr = 0;
          n_wr_addr = rwa; n_wb = wbs ? rdata : a; n_new_pc = npc;
          step();
          bus.dmem_ack = 1'b0;
          done = 1;
        end else if (c == int'(TO)) begin
          x_stall = 0; bubble(1'b1);
          step();
          done = 1;
        end else begin
          x_stall = 1; bubble(1'b0);
          step();
        end
      end
      x_req = 1'b0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " dmem_req"}, bus.dmem_req, 0);
    chk({tag, " dmem_we"}, bus.dmem_we, 0);
    chk({tag, " dmem_addr"}, bus.dmem_addr, 0);
    chk({tag, " dmem_wdata"}, bus.dmem_wdata, 0);
    chk({tag, " stall_out"}, stall_out, 0);
    chk({tag, " bus_error_out"}, bus_error_out, 0);
    chk({tag, " reg_wr_en_out"}, reg_wr_en_out, 0);
    chk({tag, " reg_wr_addr_out"}, reg_wr_addr_out, 0);
    chk({tag, " wb_data_out"}, wb_data_out, 0);
    chk({tag, " select_new_pc_out"}, select_new_pc_out, 0);
    chk({tag, " new_pc_out"}, new_pc_out, 0);
  endtask

  initial begin
    int s0, r0, b0;
    set_inputs(0, 0, '0, '0, 0, '0, 0, 0, '0);
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    model_reset();
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ALU op, then four back-to-back ops without bubbles.
    do_instr(0, 0, '0, 32'hCAFE, 1, 5'd3, 0, 0, '0, 0, '0);
    chk("alu wb_data_out", wb_data_out, 32'hCAFE);
    chk("alu reg_wr_en_out", reg_wr_en_out, 1);
    s0 = cnt_stall;
    for (int i = 0; i < 4; i++) begin
      do_instr(0, 0, '0, 32'h100 + 32'(i), 1, 5'(i + 1), 0, 0, '0, 0, '0);
    end
    chk("stream stall cycles", cnt_stall - s0, 0);

    // Load, ack in the 3rd ACCESS cycle.
    s0 = cnt_stall; r0 = cnt_req;
    do_instr(1, 0, '0, 32'h10, 1, 5'd5, 1, 0, '0, 3, 32'hDEADBEEF);
    chk("load stall cycles", cnt_stall - s0, 3);
    chk("load req cycles", cnt_req - r0, 3);
    chk("load reg_wr_en_out", reg_wr_en_out, 1);
    chk("load reg_wr_addr_out", reg_wr_addr_out, 5);
    chk("load wb_data_out", wb_data_out, 32'hDEADBEEF);

    // Store with same-cycle ack; then rd+wr together acts as a store.
    s0 = cnt_stall; r0 = cnt_req;
    do_instr(0, 1, 32'h12345678, 32'h20, 0, '0, 0, 0, '0, 1, '0);
    chk("store stall cycles", cnt_stall - s0, 1);
    chk("store req cycles", cnt_req - r0, 1);
    do_instr(1, 1, 32'hA5A5_0F0F, 32'h44, 1, 5'd7, 0, 0, '0, 2, 32'h1111_2222);
    chk("rd+wr wb_data_out is alu", wb_data_out, 32'h44);

    // Branch redirect passes through.
    do_instr(0, 0, '0, 32'h8, 0, 5'd1, 0, 1, 20'h1234, 0, '0);
    chk("redirect select_new_pc_out", select_new_pc_out, 1);
    chk("redirect new_pc_out", new_pc_out, 20'h1234);

    // Misaligned load.
    s0 = cnt_stall; r0 = cnt_req;
    do_instr(1, 0, '0, 32'h13, 1, 5'd9, 1, 0, '0, 0, '0);
    chk("misaligned req cycles", cnt_req - r0, 0);
    chk("misaligned stall cycles", cnt_stall - s0, 0);
    chk("misaligned bus_error_out", bus_error_out, 1);
    chk("misaligned reg_wr_en_out", reg_wr_en_out, 0);
    do_instr(0, 0, '0, 32'h0, 0, '0, 0, 0, '0, 0, '0);
    chk("misaligned error pulse ends", bus_error_out, 0);

    // Timeout.
    s0 = cnt_stall; r0 = cnt_req; b0 = cnt_berr;
    do_instr(1, 0, '0, 32'h40, 1, 5'd4, 1, 0, '0, 0, '0);
    chk("timeout req cycles", cnt_req - r0, int'(TO));
    chk("timeout stall cycles", cnt_stall - s0, int'(TO));
    chk("timeout bus_error_out", bus_error_out, 1);
    chk("timeout reg_wr_en_out", reg_wr_en_out, 0);
    do_instr(0, 0, '0, 32'h0, 0, '0, 0, 0, '0, 0, '0);
    chk("timeout error pulses", cnt_berr - b0, 1);

    // Reset asserted mid-ACCESS, then late acks after release.
    set_inputs(1, 0, '0, 32'h80, 1, 5'd6, 1, 0, '0);
    x_req = 0; x_stall = 1; bubble(1'b0);
    step();
    x_req = 1; x_we = 0; x_addr = 20'h20; x_wdata = '0; x_stall = 1; bubble(1'b0);
    step();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid-access reset");
    set_inputs(0, 0, '0, 32'h77, 0, 5'd2, 1, 0, '0);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      x_req = 0; x_stall = 0;
      n_wr_en = 0; n_sel_pc = 0; n_fields = 1; n_berr = 0;
      n_wr_addr = 5'd2; n_wb = 32'h77; n_new_pc = '0;
      step();
    end
    chk("late ack wb_data_out", wb_data_out, 32'h77);
    chk("late ack reg_wr_en_out", reg_wr_en_out, 0);
    bus.dmem_ack = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
